// File: rtl/stable_matching_seq.sv
// stable_matching_seq: sequential Gale-Shapley matching, one proposal per RUN cycle
module stable_matching_seq #(
  parameter int Kr = 10,
  parameter int Ks = Kr,
  parameter int S = 10,
  parameter int R = S,
  localparam int logS = $clog2(S),
  localparam int logR = $clog2(R),
  localparam int PW = $clog2(Ks + 1),
  localparam int CW = $clog2(S * Ks + 1),
  localparam int RW = R * Kr * logS,
  localparam int PIW = RW + S * Ks * logR
) (
  input  logic           clk,
  input  logic           rst,
  input  logic           start,
  input  logic [PIW-1:0] p_input,
  output logic           busy,
  output logic           done,
  output logic [R*logS:0] o,
  output logic [R-1:0]   r_matched,
  output logic [CW-1:0]  proposals
);
  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;
  state_t r_st, w_nst;
  logic [PIW-1:0] r_p;
  logic [PW-1:0] r_pc [S];
  logic [S-1:0] r_sm;
  logic [logS-1:0] r_pt [R];
  logic [R-1:0] r_rm;
  logic [CW-1:0] r_prop;
  logic r_fin;
  logic w_found, w_hit, w_win, w_acc;
  logic [logS-1:0] w_s, w_h, w_e;
  logic [logR-1:0] w_r;
  always_comb begin
    w_found = 1'b0;
    w_s = '0;
    for (int i = S - 1; i >= 0; i--)
      if (!r_sm[i] && r_pc[i] != '0) begin
        w_found = 1'b1;
        w_s = logS'(i);
      end
    w_r = r_p[RW + logR * (Ks * w_s + Ks - r_pc[w_s]) +: logR];
    w_h = r_pt[w_r];
    w_hit = 1'b0;
    w_win = 1'b0;
    w_e = '0;
    // the earlier of proposer and holder in r's list wins; absent names never match
    for (int j = 0; j < Kr; j++) begin
      w_e = r_p[logS * (Kr * w_r + j) +: logS];
      if (!w_hit && (w_e == w_s || w_e == w_h)) begin
        w_hit = 1'b1;
        w_win = (w_e == w_s);
      end
    end
    w_acc = !r_rm[w_r] || w_win;
    w_nst = (r_st == RUN) ? (w_found ? RUN : DONE) : (start ? RUN : r_st);
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      r_st <= IDLE;
      r_p <= '0;
      r_sm <= '0;
      r_rm <= '0;
      r_prop <= '0;
      r_fin <= 1'b0;
      for (int i = 0; i < S; i++) r_pc[i] <= '0;
      for (int i = 0; i < R; i++) r_pt[i] <= '0;
    end else begin
      r_st <= w_nst;
      if (r_st != RUN && start) begin
        r_p <= p_input;
        r_sm <= '0;
        r_rm <= '0;
        r_prop <= '0;
        r_fin <= 1'b0;
        for (int i = 0; i < S; i++) r_pc[i] <= PW'(Ks);
        for (int i = 0; i < R; i++) r_pt[i] <= '0;
      end else if (r_st == RUN && !w_found) begin
        r_fin <= 1'b1;
      end else if (r_st == RUN) begin
        r_pc[w_s] <= r_pc[w_s] - 1'b1;
        r_prop <= r_prop + 1'b1;
        if (w_acc) begin
          r_pt[w_r] <= w_s;
          r_rm[w_r] <= 1'b1;
          r_sm[w_s] <= 1'b1;
          if (r_rm[w_r]) r_sm[w_h] <= 1'b0;
        end
      end
    end
  end
  for (genvar g = 0; g < R; g++) assign o[logS*g +: logS] = r_pt[g];
  assign o[R*logS] = r_fin;
  assign busy = (r_st == RUN);
  assign done = (r_st == DONE);
  assign r_matched = r_rm;
  assign proposals = r_prop;
endmodule

// File: tb/tb_stable_matching_seq.sv
// tb_stable_matching_seq: directed 2x2 matching cases checked through a result scoreboard
module tb_stable_matching_seq;
  logic clk = 1'b0;
  logic rst = 1'b1;
  logic start = 1'b0;
  logic [7:0] p_input = '0;
  logic busy, done;
  logic [2:0] o;
  logic [1:0] r_matched;
  logic [2:0] proposals;
  int checks = 0;
  int errors = 0;
  typedef struct packed {logic [2:0] o; logic [1:0] rm; logic [2:0] prop;} exp_t;
  exp_t sb[$];

  stable_matching_seq #(.Kr(2), .Ks(2), .S(2), .R(2)) dut (
    .clk(clk), .rst(rst), .start(start), .p_input(p_input), .busy(busy),
    .done(done), .o(o), .r_matched(r_matched), .proposals(proposals)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
    checks++;
    assert (obs === exp_v) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp_v);
    end
  endtask

  task automatic run_case(input logic [7:0] pv, input logic [2:0] eo, input logic [1:0] erm,
                          input logic [2:0] ep, input bit disturb);
    exp_t e;
    int n;
    p_input = pv;
    sb.push_back('{eo, erm, ep});
    start = 1'b1;
    tick();
    start = 1'b0;
    n = 0;
    chk("busy_after_start", busy, 1);
    chk("cleared_o", o, 0);
    chk("cleared_rm", r_matched, 0);
    chk("cleared_prop", proposals, 0);
    if (disturb) begin
      start = 1'b1;
      p_input = ~pv;
      tick();
      start = 1'b0;
      n = 1;
    end
    while (!done && n < 50) begin
      tick();
      n++;
    end
    e = sb.pop_front();
    chk("latency", n, int'(e.prop) + 1);
    chk("o", o, e.o);
    chk("r_matched", r_matched, e.rm);
    chk("proposals", proposals, e.prop);
    chk("busy_in_done", busy, 0);
    tick();
    tick();
    chk("hold_done", done, 1);
    chk("hold_o", o, e.o);
    chk("hold_prop", proposals, e.prop);
  endtask

  initial begin
    tick();
    tick();
    rst = 1'b0;
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_o", o, 0);
    chk("rst_rm", r_matched, 0);
    chk("rst_prop", proposals, 0);
    run_case(8'hA9, 3'b101, 2'b11, 3'd3, 1'b0);
    run_case(8'hAA, 3'b110, 2'b11, 3'd3, 1'b0);
    run_case(8'h08, 3'b100, 2'b01, 3'd3, 1'b0);
    p_input = 8'hA9;
    start = 1'b1;
    tick();
    start = 1'b0;
    tick();
    tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    chk("abort_busy", busy, 0);
    chk("abort_done", done, 0);
    chk("abort_o", o, 0);
    chk("abort_rm", r_matched, 0);
    chk("abort_prop", proposals, 0);
    tick();
    chk("abort_idle", busy, 0);
    run_case(8'hA9, 3'b101, 2'b11, 3'd3, 1'b0);
    run_case(8'hA9, 3'b101, 2'b11, 3'd3, 1'b1);
    run_case(8'hAA, 3'b110, 2'b11, 3'd3, 1'b0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
